dff_response_checker: RTL and testbench

Synthesizable response checker for the positive-edge D flip-flop with set/reset. It sits on the read side of a flop test harness: it takes the S/R/D vector driven into the flop plus the flop's Q/NQ outputs, runs a cycle-accurate reference model, and reports mismatches. A sticky pass/fail flag, a first-failing-vector index and saturating counters let a harness or board-level top read the verdict without a simulator.

---
 rtl/dff_check_pkg.sv | 19 +
 rtl/sat_counter.sv | 30 +++
 rtl/dff_response_checker.sv | 140 ++++++++++++++
 tb/tb_dff_response_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dff_check_pkg.sv
// Shared types and the reference next-state rule for the set/reset D flop checker.
package dff_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Reset dominates set, set dominates data; with no enable the flop always captures D.
  function automatic logic next_q(input logic s, input logic r, input logic d, input logic q);
    if (r)           next_q = 1'b0;
    else if (s)      next_q = 1'b1;
    else if (d == q) next_q = q;
    else             next_q = d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/dff_response_checker.sv
// Read-side checker for a set/reset D flop: accept stage updates the model, compare stage one cycle later.
module dff_response_checker
  import dff_check_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             stim_valid,
  input  logic             stim_s,
  input  logic             stim_r,
  input  logic             stim_d,
  input  logic             dut_q,
  input  logic             dut_nq,
  output logic             busy,
  output logic             done,
  output logic             err_pulse,
  output logic             fail,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  state_e state_q, state_d;
  logic   run_entry;
  logic   accept;
  logic   mismatch;

  logic             exp_q_q, exp_q_d;
  logic             exp_known_q, exp_known_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_idx_q, pend_idx_d;
  logic             err_pulse_q;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] first_q, first_d;

  always_comb begin
    state_d   = state_q;
    run_entry = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == RUN) && stim_valid;

  // exp_known is always set by the time a compare is pending; the gate only documents that.
  assign mismatch = pend_q && exp_known_q && ((dut_q != exp_q_q) || (dut_nq == dut_q));

  always_comb begin
    exp_q_d     = exp_q_q;
    exp_known_d = exp_known_q;
    pend_d      = accept;
    pend_idx_d  = pend_idx_q;
    fail_d      = fail_q;
    first_d     = first_q;
    if (run_entry) begin
      exp_known_d = 1'b0;
      fail_d      = 1'b0;
      first_d     = '0;
    end
    if (accept) begin
      exp_q_d     = next_q(stim_s, stim_r, stim_d, exp_q_q);
      exp_known_d = 1'b1;
      pend_idx_d  = vec_cnt;
    end
    if (mismatch && !fail_q) begin
      fail_d  = 1'b1;
      first_d = pend_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_q_q     <= 1'b0;
      exp_known_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      err_pulse_q <= 1'b0;
      fail_q      <= 1'b0;
      first_q     <= '0;
    end else begin
      state_q     <= state_d;
      exp_q_q     <= exp_q_d;
      exp_known_q <= exp_known_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      err_pulse_q <= mismatch;
      fail_q      <= fail_d;
      first_q     <= first_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_entry),
    .inc   (accept),
    .count (vec_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_entry),
    .inc   (mismatch),
    .count (err_cnt)
  );

  assign err_pulse     = err_pulse_q;
  assign fail          = fail_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: a 16-bit and a 4-bit instance share stimulus and an emulated flop.
module tb_dff_response_checker;
  import dff_check_pkg::*;

  logic clk = 1'b0;
  logic rst, start, stop, stim_valid, stim_s, stim_r, stim_d, dut_q, dut_nq;
  logic busy, done, err_pulse, fail;
  logic [15:0] vec_cnt, err_cnt, first_err_idx;
  logic busy4, done4, err_pulse4, fail4;
  logic [3:0] vec_cnt4, err_cnt4, first_err_idx4;

  always #5 clk = ~clk;

  dff_response_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stim_valid(stim_valid),
    .stim_s(stim_s), .stim_r(stim_r), .stim_d(stim_d), .dut_q(dut_q), .dut_nq(dut_nq),
    .busy(busy), .done(done), .err_pulse(err_pulse), .fail(fail),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  dff_response_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stim_valid(stim_valid),
    .stim_s(stim_s), .stim_r(stim_r), .stim_d(stim_d), .dut_q(dut_q), .dut_nq(dut_nq),
    .busy(busy4), .done(done4), .err_pulse(err_pulse4), .fail(fail4),
    .vec_cnt(vec_cnt4), .err_cnt(err_cnt4), .first_err_idx(first_err_idx4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: run phase flags, unbounded integer counters, one pending compare.
  bit m_run, m_drain, m_done, m_exp, pend, pend_exp, sb_fail, sb_pulse, fl_q;
  int sb_vec, sb_err, sb_first, pend_idx, fl_fault;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One clock cycle: drive inputs and the emulated flop outputs, then advance the model past the edge.
  task automatic step(input bit v, input bit s, input bit r, input bit d,
                      input int fault = 0, input bit stp = 1'b0, input bit strt = 1'b0);
    bit acc, bad;
    stim_valid = v; stim_s = s; stim_r = r; stim_d = d; stop = stp; start = strt;
    dut_q  = (fl_fault == 1) ? ~fl_q : fl_q;
    dut_nq = (fl_fault == 2) ? dut_q : ~dut_q;
    acc = v && m_run;
    bad = pend && ((dut_q != pend_exp) || (dut_nq == dut_q));
    @(posedge clk); #1;
    if (rst) begin
      m_run = 0; m_drain = 0; m_done = 0; pend = 0; sb_pulse = 0;
      sb_fail = 0; sb_vec = 0; sb_err = 0; sb_first = 0;
    end else begin
      sb_pulse = bad;
      if (bad) begin
        sb_err++;
        if (!sb_fail) begin sb_fail = 1; sb_first = pend_idx; end
      end
      pend = acc;
      if (acc) begin
        m_exp = next_q(s, r, d, m_exp); pend_exp = m_exp; pend_idx = sb_vec; sb_vec++;
      end
      if (m_run) begin
        if (stp) begin m_run = 0; m_drain = 1; end
      end else if (m_drain) begin
        m_drain = 0; m_done = 1;
      end else if (strt) begin
        m_run = 1; m_done = 0; sb_vec = 0; sb_err = 0; sb_fail = 0; sb_first = 0;
      end
    end
    if (v) begin fl_q = r ? 1'b0 : (s ? 1'b1 : d); fl_fault = fault; end
    else fl_fault = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic end_run();
    step(0, 0, 0, 0, 0, 1'b1);
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_checks++; if ({busy, done, err_pulse, fail} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags got %b need 0000", {busy, done, err_pulse, fail}); end
    n_checks++; if ({vec_cnt, err_cnt, first_err_idx} !== 48'd0) begin n_fail++;
      $display("FAIL reset_counts got %h need 0", {vec_cnt, err_cnt, first_err_idx}); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    bit seen = 0;
    step(0, 0, 0, 0, 0, 0, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b need 1", busy); end
    step(1, 0, 0, 1); seen |= err_pulse;
    step(1, 0, 0, 0); seen |= err_pulse;
    step(1, 1, 0, 0); seen |= err_pulse;
    step(1, 0, 1, 0); seen |= err_pulse;
    for (int i = 0; i < 2; i++) begin step(0, 0, 0, 0); seen |= err_pulse; end
    n_checks++; if (vec_cnt !== 16'd4) begin n_fail++; $display("FAIL basic_vec got %0d need 4", vec_cnt); end
    n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_err got %0d need 0", err_cnt); end
    n_checks++; if ({fail, seen} !== 2'b00) begin n_fail++; $display("FAIL basic_fail got %b need 00", {fail, seen}); end
    step(0, 0, 0, 0, 0, 1'b1);
    n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL basic_drain got %b need 10", {busy, done}); end
    idle(1);
    n_checks++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL basic_done got %b need 01", {busy, done}); end
  endtask

  task automatic test_set_reset_conflict();
    step(0, 0, 0, 0, 0, 0, 1'b1);
    step(1, 1, 1, 0, 1);
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL sr_early_pulse got %b need 0", err_pulse); end
    idle(1);
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL sr_pulse got %b need 1", err_pulse); end
    n_checks++; if ({err_cnt, first_err_idx} !== {16'd1, 16'd0}) begin n_fail++;
      $display("FAIL sr_cnt_idx got %0d/%0d need 1/0", err_cnt, first_err_idx); end
    n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL sr_fail got %b need 1", fail); end
    idle(1);
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL sr_pulse_width got %b need 0", err_pulse); end
    end_run();
  endtask

  task automatic test_nq_fault();
    step(0, 0, 0, 0, 0, 0, 1'b1);
    n_checks++; if ({fail, err_cnt} !== 17'd0) begin n_fail++; $display("FAIL nq_clear got %h need 0", {fail, err_cnt}); end
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1'($urandom_range(0, 1)), (i == 3 || i == 5) ? 2 : 0);
      if (i == 4) begin
        n_checks++; if ({err_cnt, first_err_idx} !== {16'd1, 16'd3}) begin n_fail++;
          $display("FAIL nq_first got %0d/%0d need 1/3", err_cnt, first_err_idx); end
      end
    end
    idle(2);
    n_checks++; if ({err_cnt, first_err_idx} !== {16'd2, 16'd3}) begin n_fail++;
      $display("FAIL nq_second got %0d/%0d need 2/3", err_cnt, first_err_idx); end
    end_run();
  endtask

  task automatic test_stop_drain();
    step(0, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1'(i));
    step(1, 0, 0, 1, 1, 1'b1);
    n_checks++; if ({busy, done, err_cnt} !== {2'b10, 16'd0}) begin n_fail++;
      $display("FAIL stop_drain got busy/done %b%b err %0d need 10 err 0", busy, done, err_cnt); end
    step(0, 0, 0, 0, 0, 0, 1'b1);
    n_checks++; if ({done, err_cnt, err_pulse} !== {1'b1, 16'd1, 1'b1}) begin n_fail++;
      $display("FAIL stop_done got done %b err %0d pulse %b need 1 1 1", done, err_cnt, err_pulse); end
    step(1, 0, 0, 1, 0, 1'b1);
    n_checks++; if ({done, vec_cnt} !== {1'b1, 16'd4}) begin n_fail++;
      $display("FAIL stop_ignore got done %b vec %0d need 1 4", done, vec_cnt); end
  endtask

  task automatic test_rst_abort();
    step(0, 0, 0, 0, 0, 0, 1'b1);
    step(1, 0, 0, 1, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_checks++; if ({busy, done, err_pulse, fail} !== 4'b0000) begin n_fail++;
      $display("FAIL abort_flags got %b need 0000", {busy, done, err_pulse, fail}); end
    n_checks++; if ({vec_cnt, err_cnt, first_err_idx} !== 48'd0) begin n_fail++;
      $display("FAIL abort_counts got %h need 0", {vec_cnt, err_cnt, first_err_idx}); end
    idle(1);
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_stale got %b need 0", err_pulse); end
    step(0, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1'(i & 1));
    idle(2);
    n_checks++; if ({busy, fail, err_cnt, vec_cnt} !== {2'b10, 16'd0, 16'd3}) begin n_fail++;
      $display("FAIL abort_rerun got busy %b fail %b err %0d vec %0d need 1 0 0 3", busy, fail, err_cnt, vec_cnt); end
    end_run();
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1'($urandom_range(0, 1)), 1);
    idle(2);
    n_checks++; if ({vec_cnt4, err_cnt4} !== 8'hFF) begin n_fail++;
      $display("FAIL sat_cnt4 got %0d/%0d need 15/15", vec_cnt4, err_cnt4); end
    n_checks++; if ({fail4, first_err_idx4} !== 5'b1_0000) begin n_fail++;
      $display("FAIL sat_fail4 got %b idx %0d need 1 idx 0", fail4, first_err_idx4); end
    n_checks++; if ({vec_cnt, err_cnt} !== {16'd20, 16'd20}) begin n_fail++;
      $display("FAIL sat_cnt16 got %0d/%0d need 20/20", vec_cnt, err_cnt); end
    end_run();
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 400; c++) begin
      k = int'($urandom_range(0, 19));
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), (k == 0) ? 1 : ((k == 1) ? 2 : 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0));
      n_checks++; if ({busy, done} !== {m_run | m_drain, m_done}) begin n_fail++;
        $display("FAIL rnd_state c%0d got %b%b need %b%b", c, busy, done, m_run | m_drain, m_done); end
      n_checks++; if ({err_pulse, fail} !== {sb_pulse, sb_fail}) begin n_fail++;
        $display("FAIL rnd_flags c%0d got %b%b need %b%b", c, err_pulse, fail, sb_pulse, sb_fail); end
      n_checks++; if (vec_cnt !== 16'(sat(sb_vec, 65535))) begin n_fail++;
        $display("FAIL rnd_vec c%0d got %0d need %0d", c, vec_cnt, sb_vec); end
      n_checks++; if (err_cnt !== 16'(sat(sb_err, 65535))) begin n_fail++;
        $display("FAIL rnd_err c%0d got %0d need %0d", c, err_cnt, sb_err); end
      n_checks++; if (first_err_idx !== 16'(sat(sb_first, 65535))) begin n_fail++;
        $display("FAIL rnd_idx c%0d got %0d need %0d", c, first_err_idx, sb_first); end
      n_checks++; if ({busy4, done4, err_pulse4, fail4} !== {m_run | m_drain, m_done, sb_pulse, sb_fail}) begin n_fail++;
        $display("FAIL rnd_flags4 c%0d got %b", c, {busy4, done4, err_pulse4, fail4}); end
      n_checks++; if ({vec_cnt4, err_cnt4, first_err_idx4} !==
                      {4'(sat(sb_vec, 15)), 4'(sat(sb_err, 15)), 4'(sat(sb_first, 15))}) begin n_fail++;
        $display("FAIL rnd_cnt4 c%0d got %0d/%0d/%0d need %0d/%0d/%0d", c, vec_cnt4, err_cnt4, first_err_idx4,
                 sat(sb_vec, 15), sat(sb_err, 15), sat(sb_first, 15)); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; stim_valid = 0; stim_s = 0; stim_r = 0; stim_d = 0;
    dut_q = 0; dut_nq = 1;
    m_run = 0; m_drain = 0; m_done = 0; m_exp = 0; pend = 0; pend_exp = 0;
    sb_fail = 0; sb_pulse = 0; fl_q = 0; sb_vec = 0; sb_err = 0; sb_first = 0; pend_idx = 0; fl_fault = 0;
    test_reset();
    test_basic();
    test_set_reset_conflict();
    test_nq_fault();
    test_stop_drain();
    test_rst_abort();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
